// File: rtl/draw_bar_overlay_pkg.sv
// draw_bar_overlay_pkg: bar mode encoding, fixed overlay colours and the
// signed coordinate type shared by the bar overlay files.
package draw_bar_overlay_pkg;

  typedef enum logic [1:0] {
    GROW_RIGHT = 2'd0,
    GROW_LEFT  = 2'd1,
    CENTRED    = 2'd2,
    BAR_OFF    = 2'd3
  } bar_mode_t;

  localparam logic [11:0] BAR_FLASH_RGB  = 12'hFFF;
  localparam logic [11:0] BAR_BORDER_RGB = 12'h000;

  // One bit wider than a 12-bit signed compare so that anchor+frame+border
  // near the right edge cannot wrap negative.
  localparam int COORD_W = 13;
  typedef logic signed [COORD_W-1:0] coord_t;

  // Halve each 4-bit channel of a 12-bit RGB value.
  function automatic logic [11:0] half_rgb(input logic [11:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

endpackage

// File: rtl/draw_bar_overlay_if.sv
// vga_if: pixel timing plus rgb passed between VGA pipeline stages.
// 'out' is the driving side of a stage, 'in' the receiving side.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_bar_overlay_animator.sv
// bar_animator: per-bar frame-tick state. Moves the displayed value toward
// the clamped target, registers the fill length one cycle after the tick
// and runs the damage-flash counter.
module bar_animator
  import draw_bar_overlay_pkg::*;
#(
  parameter int VALUE_W      = 7,
  parameter int MAX_UNITS    = 100,
  parameter int PX_PER_UNIT  = 3,
  parameter int FLASH_FRAMES = 16,
  parameter int STEP_UNITS   = 1
) (
  input  logic             clk60MHz,
  input  logic             rst,
  input  logic             i_tick,
  input  logic [VALUE_W:0] i_value,
  input  bar_mode_t        i_mode,
  output logic [11:0]      o_len,
  output logic             o_neg,
  output logic             o_flash
);
  localparam int DW   = VALUE_W + 2;
  localparam int FC_W = ($clog2(FLASH_FRAMES + 1) < 2) ? 2 : $clog2(FLASH_FRAMES + 1);
  localparam logic signed [DW:0]   STEP_W = (DW+1)'(STEP_UNITS);
  localparam logic signed [DW-1:0] STEP_D = DW'(STEP_UNITS);

  logic [VALUE_W-1:0]   w_mag, w_tgt_mag, r_prev_mag;
  logic signed [DW-1:0] w_tgt_pos, w_tgt, w_next, r_disp;
  logic signed [DW:0]   w_diff;
  logic [DW-1:0]        w_abs;
  logic [FC_W-1:0]      r_flash;
  logic [11:0]          r_len;
  logic                 r_tick_d;

  assign w_mag     = i_value[VALUE_W-1:0];
  assign w_tgt_mag = (w_mag > VALUE_W'(MAX_UNITS)) ? VALUE_W'(MAX_UNITS) : w_mag;
  assign w_tgt_pos = $signed({2'b00, w_tgt_mag});
  // direction bit only means something for centred bars
  assign w_tgt     = (i_mode == CENTRED && i_value[VALUE_W]) ? -w_tgt_pos : w_tgt_pos;
  assign w_diff    = {w_tgt[DW-1], w_tgt} - {r_disp[DW-1], r_disp};
  assign w_abs     = r_disp[DW-1] ? -r_disp : r_disp;

  // step toward target, landing exactly on it when within one step
  always_comb begin
    w_next = w_tgt;
    if (w_diff > STEP_W)       w_next = r_disp + STEP_D;
    else if (w_diff < -STEP_W) w_next = r_disp - STEP_D;
  end

  // tick-driven value/flash update, fill length follows one cycle later
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      r_disp     <= '0;
      r_prev_mag <= '0;
      r_flash    <= '0;
      r_len      <= '0;
      r_tick_d   <= 1'b0;
    end else begin
      r_tick_d <= i_tick;
      if (i_tick) begin
        r_disp     <= w_next;
        r_prev_mag <= w_tgt_mag;
        if (w_tgt_mag < r_prev_mag) r_flash <= FC_W'(FLASH_FRAMES);
        else if (r_flash != '0)     r_flash <= r_flash - FC_W'(1);
      end
      if (r_tick_d) r_len <= 12'(w_abs) * 12'(PX_PER_UNIT);
    end
  end

  assign o_len   = r_len;
  assign o_neg   = r_disp[DW-1];
  assign o_flash = (r_flash != '0) && r_flash[1];

endmodule

// File: rtl/draw_bar_overlay.sv
// draw_bar_overlay: draws NUM_BARS bordered, animated value bars over the
// vga_if pixel stream with one clock of latency.
// Optional: define DRAW_BAR_OVERLAY_TICKS_EN for half-brightness scale ticks
// every 10 units inside each fill.
module draw_bar_overlay
  import draw_bar_overlay_pkg::*;
#(
  parameter int NUM_BARS     = 3,
  parameter int VALUE_W      = 7,
  parameter int MAX_UNITS    = 100,
  parameter int PX_PER_UNIT  = 3,
  parameter int BAR_H        = 20,
  parameter int BORDER_W     = 5,
  parameter int FLASH_FRAMES = 16,
  parameter int STEP_UNITS   = 1
) (
  input  logic                            clk60MHz,
  input  logic                            rst,
  input  logic [NUM_BARS-1:0][VALUE_W:0]  bar_value,
  input  logic [NUM_BARS-1:0][1:0]        bar_mode,
  input  logic [NUM_BARS-1:0][10:0]       bar_xpos,
  input  logic [NUM_BARS-1:0][10:0]       bar_ypos,
  input  logic [NUM_BARS-1:0][11:0]       bar_colour,
  input  logic [NUM_BARS-1:0][11:0]       bar_colour_neg,
  vga_if.in                               in,
  vga_if.out                              out
);
  localparam coord_t FW  = coord_t'(MAX_UNITS * PX_PER_UNIT);
  localparam coord_t BW  = coord_t'(BORDER_W);
  localparam coord_t BH1 = coord_t'(BAR_H - 1);
  localparam coord_t ONE = coord_t'(1);
`ifdef DRAW_BAR_OVERLAY_TICKS_EN
  localparam coord_t TICK_PX = coord_t'(10 * PX_PER_UNIT);
`endif

  logic                      r_vblnk;
  logic                      w_tick;
  logic [NUM_BARS-1:0][11:0] w_len;
  logic [NUM_BARS-1:0]       w_neg, w_flash;
  coord_t                    w_x, w_y;
  logic [12:0]               w_px;
  logic [11:0]               w_rgb;

  assign w_tick = in.vblnk & ~r_vblnk;
  assign w_x    = $signed({2'b00, in.hcount});
  assign w_y    = $signed({2'b00, in.vcount});

  for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
    bar_animator #(
      .VALUE_W(VALUE_W), .MAX_UNITS(MAX_UNITS), .PX_PER_UNIT(PX_PER_UNIT),
      .FLASH_FRAMES(FLASH_FRAMES), .STEP_UNITS(STEP_UNITS)
    ) u_anim (
      .clk60MHz(clk60MHz), .rst(rst), .i_tick(w_tick),
      .i_value(bar_value[g]), .i_mode(bar_mode_t'(bar_mode[g])),
      .o_len(w_len[g]), .o_neg(w_neg[g]), .o_flash(w_flash[g])
    );
  end

  // Returns {hit, rgb} for one bar at pixel (x,y). A centred bar keeps its
  // anchor column empty so both directions reach the frame ends at full scale.
  function automatic logic [12:0] bar_px(
    input coord_t x, input coord_t y, input coord_t xp, input coord_t yp,
    input bar_mode_t mode, input logic [11:0] len, input logic neg,
    input logic flash, input logic [11:0] col, input logic [11:0] col_neg);
    coord_t fxl, fxh, lo, hi, l;
    logic in_frame, in_ring, in_fill;
    logic [11:0] c;
`ifdef DRAW_BAR_OVERLAY_TICKS_EN
    coord_t off;
`endif
    l   = $signed({1'b0, len});
    fxl = xp;
    fxh = xp;
    lo  = xp;
    hi  = xp - ONE;
    case (mode)
      GROW_RIGHT: begin fxh = xp + FW - ONE; hi = xp + l - ONE; end
      GROW_LEFT:  begin fxl = xp - FW + ONE; lo = xp - l + ONE; hi = xp; end
      CENTRED: begin
        fxl = xp - FW;
        fxh = xp + FW;
        if (neg) begin lo = xp - l; hi = xp - ONE; end
        else     begin lo = xp + ONE; hi = xp + l; end
      end
      default: ;
    endcase
    in_frame = x >= fxl && x <= fxh && y >= yp && y <= yp + BH1;
    in_ring  = !in_frame && x >= fxl - BW && x <= fxh + BW &&
               y >= yp - BW && y <= yp + BH1 + BW;
    in_fill  = len != '0 && x >= lo && x <= hi && y >= yp && y <= yp + BH1;
    c = flash ? BAR_FLASH_RGB : ((mode == CENTRED && neg) ? col_neg : col);
`ifdef DRAW_BAR_OVERLAY_TICKS_EN
    off = (mode == GROW_LEFT || x < xp) ? xp - x : x - xp;
    if (off != '0 && (off % TICK_PX) == '0) c = half_rgb(c);
`endif
    if (mode == BAR_OFF) return 13'd0;
    if (in_ring)         return {1'b1, BAR_BORDER_RGB};
    if (in_fill)         return {1'b1, c};
    return 13'd0;
  endfunction

  // priority mux: walk high to low so the lowest index is applied last
  always_comb begin
    w_rgb = in.rgb;
    w_px  = '0;
    for (int i = NUM_BARS - 1; i >= 0; i--) begin
      w_px = bar_px(w_x, w_y, $signed({2'b00, bar_xpos[i]}), $signed({2'b00, bar_ypos[i]}),
                    bar_mode_t'(bar_mode[i]), w_len[i], w_neg[i], w_flash[i],
                    bar_colour[i], bar_colour_neg[i]);
      if (w_px[12]) w_rgb = w_px[11:0];
    end
  end

  // single output stage: timing delayed by one clock, rgb registered alongside
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      r_vblnk    <= 1'b0;
      out.vcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      r_vblnk    <= in.vblnk;
      out.vcount <= in.vcount;
      out.vsync  <= in.vsync;
      out.vblnk  <= in.vblnk;
      out.hcount <= in.hcount;
      out.hsync  <= in.hsync;
      out.hblnk  <= in.hblnk;
      out.rgb    <= w_rgb;
    end
  end

endmodule

// File: tb/tb_draw_bar_overlay.sv
// tb_draw_bar_overlay: randomized probes against an integer reference model
// of the bar overlay, plus fixed boundary pixels taken from hand calculation.
module tb_draw_bar_overlay;
  import draw_bar_overlay_pkg::*;

  localparam int NB = 3, VW = 7, PX = 3, FWID = 300, BWID = 5, BHGT = 20;

  logic clk = 1'b0;
  logic rst;
  logic [NB-1:0][VW:0]  bar_value;
  logic [NB-1:0][1:0]   bar_mode;
  logic [NB-1:0][10:0]  bar_xpos, bar_ypos;
  logic [NB-1:0][11:0]  bar_colour, bar_colour_neg;

  vga_if vin();
  vga_if vout();

  draw_bar_overlay #(.NUM_BARS(NB)) dut (
    .clk60MHz(clk), .rst(rst),
    .bar_value(bar_value), .bar_mode(bar_mode),
    .bar_xpos(bar_xpos), .bar_ypos(bar_ypos),
    .bar_colour(bar_colour), .bar_colour_neg(bar_colour_neg),
    .in(vin), .out(vout)
  );

  always #8 clk = ~clk;

  int checks = 0, errors = 0;
  int m_disp[NB], m_prev[NB], m_flash[NB];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // frame tick in plain integers: clamp, flash on drop, step by one unit
  function automatic void model_tick();
    for (int b = 0; b < NB; b++) begin
      int mag, tgt;
      mag = int'(bar_value[b][VW-1:0]);
      if (mag > 100) mag = 100;
      tgt = (bar_mode[b] == 2'd2 && bar_value[b][VW]) ? -mag : mag;
      if (mag < m_prev[b]) m_flash[b] = 16;
      else if (m_flash[b] > 0) m_flash[b]--;
      m_prev[b] = mag;
      if (m_disp[b] < tgt) m_disp[b]++;
      else if (m_disp[b] > tgt) m_disp[b]--;
    end
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < NB; b++) begin
      m_disp[b] = 0; m_prev[b] = 0; m_flash[b] = 0;
    end
  endfunction

  function automatic logic [11:0] ref_px(input int x, input int y, input logic [11:0] rgb);
    for (int b = 0; b < NB; b++) begin
      int mode, xp, yp, len, fl, fr, lo, hi;
      mode = int'(bar_mode[b]);
      if (mode == 3) continue;
      xp  = int'(bar_xpos[b]);
      yp  = int'(bar_ypos[b]);
      len = (m_disp[b] < 0 ? -m_disp[b] : m_disp[b]) * PX;
      lo = 0; hi = -1;
      if (mode == 0) begin
        fl = xp; fr = xp + FWID - 1; lo = xp; hi = xp + len - 1;
      end else if (mode == 1) begin
        fl = xp - FWID + 1; fr = xp; lo = xp - len + 1; hi = xp;
      end else begin
        fl = xp - FWID; fr = xp + FWID;
        if (m_disp[b] > 0) begin lo = xp + 1; hi = xp + len; end
        else if (m_disp[b] < 0) begin lo = xp - len; hi = xp - 1; end
      end
      if (x < fl - BWID || x > fr + BWID || y < yp - BWID || y > yp + BHGT - 1 + BWID) continue;
      if (x < fl || x > fr || y < yp || y > yp + BHGT - 1) return 12'h000;
      if (x >= lo && x <= hi) begin
        if ((m_flash[b] / 2) % 2 == 1) return 12'hFFF;
        return (mode == 2 && m_disp[b] < 0) ? bar_colour_neg[b] : bar_colour[b];
      end
    end
    return rgb;
  endfunction

  task automatic drive(input int x, input int y, input logic [11:0] rgb, input logic vb);
    vin.hcount = 11'(x);
    vin.vcount = 11'(y);
    vin.rgb    = rgb;
    vin.vblnk  = vb;
    vin.hsync  = 1'($urandom);
    vin.vsync  = 1'($urandom);
    vin.hblnk  = 1'($urandom);
  endtask

  task automatic tick();
    drive(0, 0, 12'h000, 1'b1);
    @(posedge clk); #1;
    drive(0, 0, 12'h000, 1'b0);
    @(posedge clk); #1;
    model_tick();
  endtask

  task automatic probe(input string tag, input int x, input int y, input bit pass,
                       input logic [11:0] col);
    logic [11:0] r;
    r = 12'($urandom);
    drive(x, y, r, 1'b0);
    @(posedge clk); #1;
    chk(tag, 32'(vout.rgb), 32'(pass ? r : col));
  endtask

  task automatic mprobe(input int x, input int y);
    logic [11:0] r, e;
    r = 12'($urandom);
    e = ref_px(x, y, r);
    drive(x, y, r, 1'b0);
    @(posedge clk); #1;
    chk("model_rgb", 32'(vout.rgb), 32'(e));
    chk("hcount_dly", 32'(vout.hcount), 32'(x));
  endtask

  task automatic rnd_probes(input int n, input int x0, input int x1, input int y0, input int y1);
    for (int k = 0; k < n; k++)
      mprobe(int'($urandom_range(x1, x0)), int'($urandom_range(y1, y0)));
  endtask

  initial begin
    int h1;
    bar_value      = '0;
    bar_value[0]   = 8'd50;  bar_value[1] = 8'h02;  bar_value[2] = 8'd80;
    bar_mode[0]    = 2'd0;   bar_mode[1]  = 2'd3;   bar_mode[2]  = 2'd3;
    bar_xpos[0]    = 11'd200; bar_ypos[0] = 11'd40;
    bar_xpos[1]    = 11'd640; bar_ypos[1] = 11'd40;
    bar_xpos[2]    = 11'd100; bar_ypos[2] = 11'd300;
    bar_colour[0]  = 12'h0F0; bar_colour_neg[0] = 12'hF00;
    bar_colour[1]  = 12'h00F; bar_colour_neg[1] = 12'h0FF;
    bar_colour[2]  = 12'h888; bar_colour_neg[2] = 12'h444;
    model_reset();

    // reset with live timing
    rst = 1'b1;
    repeat (3) begin
      drive(int'($urandom_range(2047, 0)), int'($urandom_range(2047, 0)),
            12'($urandom), 1'($urandom));
      @(posedge clk); #1;
      chk("rst_rgb", 32'(vout.rgb), 32'h0);
      chk("rst_timing", 32'({vout.vcount, vout.hcount, vout.vsync, vout.vblnk,
                             vout.hsync, vout.hblnk}), 32'h0);
    end
    rst = 1'b0;
    h1 = int'($urandom_range(2047, 1));
    drive(h1, 7, 12'h123, 1'b0);
    @(posedge clk); #1;
    chk("first_hcount", 32'(vout.hcount), 32'(h1));

    // grow right to 50
    repeat (50) begin
      tick();
      rnd_probes(2, 190, 510, 30, 70);
    end
    probe("gr_fill_end", 349, 50, 0, 12'h0F0);
    probe("gr_fill_start", 200, 40, 0, 12'h0F0);
    probe("gr_past_fill", 350, 50, 1, 12'h000);
    probe("gr_border_l", 195, 50, 0, 12'h000);
    probe("gr_border_l_in", 199, 59, 0, 12'h000);
    probe("gr_border_r", 504, 50, 0, 12'h000);
    probe("gr_outside_r", 505, 50, 1, 12'h000);
    probe("gr_border_top", 300, 35, 0, 12'h000);
    probe("gr_outside_top", 300, 34, 1, 12'h000);

    // drop to 30: flash and step down
    bar_value[0] = 8'd30;
    tick();
    probe("flash_first", 200, 45, 0, 12'h0F0);
    tick();
    probe("flash_white", 200, 45, 0, 12'hFFF);
    repeat (23) begin
      tick();
      mprobe(200, 45);
      rnd_probes(2, 190, 360, 30, 70);
    end
    probe("drop_stop_fill", 289, 45, 0, 12'h0F0);
    probe("drop_stop_past", 290, 45, 1, 12'h000);

    // centred, negative 2
    bar_mode[0] = 2'd2; bar_xpos[0] = 11'd640; bar_value[0] = 8'h82;
    repeat (40) begin
      tick();
      rnd_probes(1, 600, 680, 35, 65);
    end
    probe("cen_neg_lo", 634, 42, 0, 12'hF00);
    probe("cen_neg_hi", 639, 42, 0, 12'hF00);
    probe("cen_neg_before", 633, 42, 1, 12'h000);
    probe("cen_anchor", 640, 42, 1, 12'h000);
    probe("cen_border_l", 339, 42, 0, 12'h000);

    bar_value[0] = 8'h02;
    repeat (4) begin
      tick();
      rnd_probes(6, 630, 650, 38, 62);
    end
    probe("cen_pos_lo", 641, 42, 0, 12'h0F0);
    probe("cen_pos_hi", 646, 42, 0, 12'h0F0);
    probe("cen_pos_past", 647, 42, 1, 12'h000);

    // overlap: bar 1 on same spot
    bar_mode[1] = 2'd2;
    probe("ovl_bar0_wins", 643, 50, 0, 12'h0F0);
    rnd_probes(10, 330, 950, 30, 70);
    bar_mode[0] = 2'd3;
    probe("ovl_bar1_shown", 643, 50, 0, 12'h00F);
    rnd_probes(10, 330, 950, 30, 70);

    // grow left near the left edge, clamped target
    bar_mode[1] = 2'd3;
    bar_mode[0] = 2'd1; bar_xpos[0] = 11'd10; bar_ypos[0] = 11'd100;
    bar_value[0] = 8'h7F;
    repeat (100) tick();
    probe("gl_fill_x0", 0, 105, 0, 12'h0F0);
    probe("gl_fill_anchor", 10, 105, 0, 12'h0F0);
    probe("gl_border_r", 15, 105, 0, 12'h000);
    probe("gl_outside_r", 16, 105, 1, 12'h000);
    probe("gl_no_wrap_2047", 2047, 105, 1, 12'h000);
    probe("gl_no_wrap_2040", 2040, 95, 1, 12'h000);
    rnd_probes(30, 0, 2047, 90, 130);
    tick();
    probe("gl_clamped", 0, 110, 0, 12'h0F0);

    // mid-run reset, animation restarts from zero
    rst = 1'b1;
    drive(5, 105, 12'hABC, 1'b0);
    @(posedge clk); #1;
    chk("midrst_rgb", 32'(vout.rgb), 32'h0);
    rst = 1'b0;
    model_reset();
    tick();
    probe("restart_fill", 8, 105, 0, 12'h0F0);
    probe("restart_past", 7, 105, 1, 12'h000);
    rnd_probes(10, 0, 40, 90, 130);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_bar_overlay.md
Name: draw_bar_overlay

Overview:
- Parametrised successor of the fixed two-HP-bar-plus-wind overlay stage in the VGA chain.
- Draws NUM_BARS bordered value bars over the incoming pixel stream. Each bar grows right, grows left, or grows from its centre according to a signed value.
- Displayed bar values animate toward their targets once per frame. A bar flashes after its value drops (damage feedback).
- Sits in the vga_if pipeline between the game-logic renderers and the output/mouse stage, clocked at 60 MHz.

Parameters:
- NUM_BARS, 3, number of bars drawn (1..8).
- VALUE_W, 7, width of each unsigned magnitude field.
- MAX_UNITS, 100, full-scale magnitude; larger targets clamp to this.
- PX_PER_UNIT, 3, fill pixels per unit (1..15).
- BAR_H, 20, fill height in lines.
- BORDER_W, 5, border thickness in pixels.
- FLASH_FRAMES, 16, frames a bar flashes after a decrease.
- STEP_UNITS, 1, maximum change of the displayed value per frame.

Ports:
- clk60MHz  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- bar_value  in  NUM_BARS x (VALUE_W+1)  per bar: MSB is direction (0 = positive/right, 1 = negative/left), LSBs are the magnitude
- bar_mode  in  NUM_BARS x 2  0 = GROW_RIGHT, 1 = GROW_LEFT, 2 = CENTRED, 3 = disabled
- bar_xpos  in  NUM_BARS x 11  anchor x (left edge, right edge, or centre according to mode)
- bar_ypos  in  NUM_BARS x 11  top line of the fill rectangle
- bar_colour  in  NUM_BARS x 12  fill colour for the positive direction
- bar_colour_neg  in  NUM_BARS x 12  fill colour for the negative direction (CENTRED mode only)
- in  vga_if.in  -  timing and rgb from the upstream stage
- out  vga_if.out  -  timing and rgb to the downstream stage

Interface decision: one clock (clk60MHz). Reset rst is synchronous and active-high.

Behaviour:
- Reset: every out field is 0. Displayed values, fill lengths and flash counters are 0. The frame-tick edge register is 0.
- Latency: timing fields of out equal the in fields delayed by exactly 1 clock. out.rgb is registered in the same stage, so total latency is 1 clock.
- Frame tick: asserted for one clock on the rising edge of in.vblnk, detected with a registered copy of vblnk. All per-bar state updates only on a frame tick, so updates never happen mid-visible area.
- Target: target = min(magnitude, MAX_UNITS) with direction = MSB. In CENTRED mode the signed target is ±target; in the other modes the MSB is ignored.
- Displayed value (signed, VALUE_W+2 bits): on a tick, move toward the target by min(|target − disp|, STEP_UNITS). Crossing zero in CENTRED mode passes through 0. It never overshoots.
- Fill length: registered the cycle after a tick as |disp| × PX_PER_UNIT in 12 bits. Rendering uses only the registered length (no multiplier in the pixel path).
- Flash counter per bar:
  - Loads FLASH_FRAMES on a tick where the new target magnitude is below the previous tick's target magnitude.
  - Otherwise decrements on each tick, saturating at 0.
  - A decrease while already flashing reloads the counter.
- Geometry: frame width FW = MAX_UNITS × PX_PER_UNIT.
  - GROW_RIGHT: frame x range [xpos, xpos+FW−1]; fill x range [xpos, xpos+len−1].
  - GROW_LEFT: frame x range [xpos−FW+1, xpos]; fill mirrored from xpos.
  - CENTRED: frame x range [xpos−FW, xpos+FW]. The fill extends right from xpos when disp>0 (colour bar_colour) and left from xpos when disp<0 (bar_colour_neg).
  - Fill y range: [ypos, ypos+BAR_H−1].
  - The border is the BORDER_W-thick ring immediately outside the frame rectangle, drawn 12'h000.
  - len=0 draws no fill.
- Flash: when flash_cnt≠0 and flash_cnt[1]=1, fill pixels are 12'hFFF instead of the fill colour.
- Pixel priority: the lowest bar index wins. Within a bar, border and fill regions are disjoint. Pixels not covered by any bar pass through as in.rgb.
- Disabled bars (mode 3) draw nothing, but their state still updates.
- Coordinates below 0 after subtraction are treated as no match: use signed 12-bit comparisons, never unsigned wrap.
- Reset mid-frame: out is forced to 0 on the reset cycle. Normal pass-through resumes on the cycle after rst deasserts. Animation restarts from 0.

Optional Feature:
- Macro: DRAW_BAR_OVERLAY_TICKS_EN.
- When defined: within each fill, any column whose offset from the anchor is a nonzero multiple of 10 × PX_PER_UNIT is drawn at half brightness (each channel >>1). The border is unaffected.
- When undefined: fills are solid. The tick logic is absent from the netlist.

Decomposition:
- variable_pkg gains: bar_mode_t enum (GROW_RIGHT, GROW_LEFT, CENTRED, BAR_OFF), BAR_FLASH_RGB = 12'hFFF, BAR_BORDER_RGB = 12'h000.
- Existing HP/wind position constants stay in variable_pkg and feed bar_xpos/bar_ypos at the top level.
- One sub-module, bar_animator: per-bar tick-driven disp/len/flash state, instantiated NUM_BARS times with a generate loop. The pixel compare and priority mux live in draw_bar_overlay.

Test Plan:
- Reset: hold rst for 3 clocks with live timing → out all 0. One clock after release, out.hcount equals the previous cycle's in.hcount.
- GROW_RIGHT bar 0 at x=200, y=40, target 50, PX_PER_UNIT=3 → disp reaches 50 after 50 ticks. On frame 51, fill covers x=200..349 and x=350 shows in.rgb. Border spans x=195..199 and x=500..504.
- Target drop 50→30 → flash counter loads 16. Fill alternates 12'hFFF/colour every 2 frames for 16 frames. disp decrements 1 per frame and stops at 30, not 29.
- CENTRED at x=640, value 9'b1_0000010 → fill x=634..639 in bar_colour_neg. Changing to +2 walks disp −2→−1→0→+1→+2 over 4 ticks.
- Overlap: bars 0 and 1 at identical coordinates → only bar 0 colours appear. Setting bar 0 mode=3 reveals bar 1.
- Edge: GROW_LEFT at x=10, FW=300 → no wrapped pixels near x=2047. Target 127 clamps to 100.
